// File: rtl/i2s_pkg.sv
// Shared I2S constants and receiver FSM state encoding.
package i2s_pkg;

    localparam int unsigned RESBIT     = 16;
    localparam int unsigned TOTAL_BITS = 2 * RESBIT + 2;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        SHIFT = 2'd1,
        WAIT  = 2'd2
    } state_e;

endpackage

// File: rtl/i2s_sync_edge.sv
// Multi-flop synchronizer with a previous-value register, giving level, rise and change.
module i2s_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_in,
    output logic q,
    output logic rise_c,
    output logic chg_c
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d_in};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign q      = sync_q[SYNC_STAGES-1];
    assign rise_c = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign chg_c  = sync_q[SYNC_STAGES-1] ^ prev_q;

endmodule

// File: rtl/i2s_receiver.sv
// Oversampling I2S receiver: recovers left/right words and publishes each stereo
// frame through a valid/ready register stage.
module i2s_receiver
    import i2s_pkg::*;
#(
    parameter int unsigned RESBIT      = i2s_pkg::RESBIT,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 64,
    parameter logic        WS_LEFT     = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bck_in,
    input  logic              ws_in,
    input  logic              data_in,
    output logic [RESBIT-1:0] left_out,
    output logic [RESBIT-1:0] right_out,
    output logic              valid,
    input  logic              ready,
    output logic              overrun,
    output logic              sync_err,
    output logic              locked
);

    localparam int unsigned CNT_W = $clog2(RESBIT + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    logic bck_rise, ws_s, data_s;
    logic unused_bck_q, unused_bck_chg, unused_ws_rise, unused_ws_chg;
    logic unused_data_rise, unused_data_chg;

    i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_bck (
        .clk(clk), .rst(rst), .d_in(bck_in),
        .q(unused_bck_q), .rise_c(bck_rise), .chg_c(unused_bck_chg)
    );
    i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ws (
        .clk(clk), .rst(rst), .d_in(ws_in),
        .q(ws_s), .rise_c(unused_ws_rise), .chg_c(unused_ws_chg)
    );
    i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_data (
        .clk(clk), .rst(rst), .d_in(data_in),
        .q(data_s), .rise_c(unused_data_rise), .chg_c(unused_data_chg)
    );

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [RESBIT-1:0] shreg_q, shreg_d;
    logic [RESBIT-1:0] left_hold_q, left_hold_d;
    logic [RESBIT-1:0] left_out_q, left_out_d;
    logic [RESBIT-1:0] right_out_q, right_out_d;
    logic              chan_q, chan_d;
    logic              ws_last_q, ws_last_d;
    logic              left_ok_q, left_ok_d;
    logic              valid_q, valid_d;
    logic              overrun_q, overrun_d;
    logic              sync_err_q, sync_err_d;
    logic              locked_q, locked_d;

    logic              ws_chg, tmo_hit, publish;
    logic [RESBIT-1:0] word;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        tmo_d       = tmo_q;
        shreg_d     = shreg_q;
        left_hold_d = left_hold_q;
        left_out_d  = left_out_q;
        right_out_d = right_out_q;
        chan_d      = chan_q;
        ws_last_d   = ws_last_q;
        left_ok_d   = left_ok_q;
        valid_d     = valid_q;
        overrun_d   = 1'b0;
        sync_err_d  = 1'b0;
        locked_d    = locked_q;
        publish     = 1'b0;
        word        = {shreg_q[RESBIT-2:0], data_s};
        ws_chg      = bck_rise && (ws_s != ws_last_q);
        tmo_hit     = !bck_rise && (tmo_q == TMO_W'(TIMEOUT - 1));

        // Saturating count of clk cycles since the last bck rise
        if (bck_rise) begin
            ws_last_d = ws_s;
            tmo_d     = '0;
        end else if (tmo_q != TMO_W'(TIMEOUT)) begin
            tmo_d = tmo_q + TMO_W'(1);
        end

        // A ws change always restarts capture; the change cycle is the delay bit
        if (ws_chg) begin
            bit_cnt_d = '0;
            chan_d    = (ws_s == WS_LEFT);
        end

        if (tmo_hit) begin
            state_d   = HUNT;
            locked_d  = 1'b0;
            left_ok_d = 1'b0;
        end else if (bck_rise) begin
            unique case (state_q)
                HUNT: begin
                    if (ws_chg) state_d = SHIFT;
                end
                SHIFT: begin
                    if (ws_chg) begin
                        sync_err_d = 1'b1;
                        locked_d   = 1'b0;
                        left_ok_d  = 1'b0;
                    end else begin
                        shreg_d   = word;
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == CNT_W'(RESBIT - 1)) begin
                            state_d = WAIT;
                            if (chan_q) begin
                                left_hold_d = word;
                                left_ok_d   = 1'b1;
                            end else if (left_ok_q) begin
                                publish     = 1'b1;
                                left_out_d  = left_hold_q;
                                right_out_d = word;
                                locked_d    = 1'b1;
                                left_ok_d   = 1'b0;
                            end
                        end
                    end
                end
                WAIT: begin
                    if (ws_chg) state_d = SHIFT;
                end
                default: state_d = HUNT;
            endcase
        end

        // Output stage handshake; a publish always wins over the drain
        if (valid_q && ready) valid_d = 1'b0;
        if (publish) begin
            valid_d   = 1'b1;
            overrun_d = valid_q && !ready;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= HUNT;
            bit_cnt_q   <= '0;
            tmo_q       <= '0;
            shreg_q     <= '0;
            left_hold_q <= '0;
            left_out_q  <= '0;
            right_out_q <= '0;
            chan_q      <= 1'b0;
            ws_last_q   <= 1'b0;
            left_ok_q   <= 1'b0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            sync_err_q  <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            tmo_q       <= tmo_d;
            shreg_q     <= shreg_d;
            left_hold_q <= left_hold_d;
            left_out_q  <= left_out_d;
            right_out_q <= right_out_d;
            chan_q      <= chan_d;
            ws_last_q   <= ws_last_d;
            left_ok_q   <= left_ok_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            sync_err_q  <= sync_err_d;
            locked_q    <= locked_d;
        end
    end

    assign left_out  = left_out_q;
    assign right_out = right_out_q;
    assign valid     = valid_q;
    assign overrun   = overrun_q;
    assign sync_err  = sync_err_q;
    assign locked    = locked_q;

endmodule
